// File: rtl/branch_issue_sched.sv
// branch_issue_sched
//
// Arbitrates the single branch functional unit among NUM_REQ branch
// reservation-station ports. The oldest eligible request (age measured from
// the ROB head, modulo 2^SEQ_W) is granted combinationally and latched into a
// one-entry issue register that feeds the branch unit. Branch-resolution
// broadcasts are applied to both the held entry and the incoming requests.
//
// State table:
//   state    | meaning
//   ST_EMPTY | issue register holds nothing
//   ST_FULL  | issue register holds a branch waiting for the branch unit
//
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   req_valid/seq/bmask/pkt : per-port request (valid, ROB tag, branch mask, payload)
//   req_grant        : one-hot (or zero) grant, same cycle as the request
//   head_seq         : ROB head tag, the origin of the age computation
//   issue_valid/pkt/seq/bmask : held entry presented to the branch unit
//   fu_ready         : branch unit accepts issue_* this cycle
//   resolve_valid/mispred/bm  : branch-resolution broadcast
module branch_issue_sched #(
    parameter int NUM_REQ = 4,
    parameter int SEQ_W   = 5,
    parameter int BM_W    = 4,
    parameter int PKT_W   = 128
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][SEQ_W-1:0]   req_seq,
    input  logic [NUM_REQ-1:0][BM_W-1:0]    req_bmask,
    input  logic [NUM_REQ-1:0][PKT_W-1:0]   req_pkt,
    output logic [NUM_REQ-1:0]              req_grant,
    input  logic [SEQ_W-1:0]                head_seq,
    output logic                            issue_valid,
    output logic [PKT_W-1:0]                issue_pkt,
    output logic [SEQ_W-1:0]                issue_seq,
    output logic [BM_W-1:0]                 issue_bmask,
    input  logic                            fu_ready,
    input  logic                            resolve_valid,
    input  logic                            resolve_mispred,
    input  logic [BM_W-1:0]                 resolve_bm
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PKT_W-1:0]   hold_pkt_q, hold_pkt_d;
    logic [SEQ_W-1:0]   hold_seq_q, hold_seq_d;
    logic [BM_W-1:0]    hold_bmask_q, hold_bmask_d;

    logic               hold_valid;
    logic               mispred_en;
    logic [BM_W-1:0]    clr;
    logic               hold_kill;
    logic               free;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic [SEQ_W-1:0]   win_age;
    logic [SEQ_W-1:0]   age;
    logic               grant_en;

    assign hold_valid = (state_q == ST_FULL);
    assign mispred_en = resolve_valid & resolve_mispred;
    assign clr        = (resolve_valid & ~resolve_mispred) ? resolve_bm : '0;
    assign hold_kill  = mispred_en & (|(hold_bmask_q & resolve_bm));
    assign free       = ~hold_valid | hold_kill | fu_ready;

    // Oldest-first selection; the strict compare keeps the lowest index on ties.
    always_comb begin
        eligible = '0;
        found    = 1'b0;
        win_idx  = '0;
        win_age  = '0;
        age      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & ~(mispred_en & (|(req_bmask[i] & resolve_bm)));
            age = req_seq[i] - head_seq;
            if (eligible[i] && (!found || age < win_age)) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
                win_age = age;
            end
        end
    end

    // No grant while reset is asserted, so requesters keep their entries.
    assign grant_en = free & found & ~reset;

    always_comb begin
        req_grant = '0;
        if (grant_en) begin
            req_grant[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_pkt_d   = hold_pkt_q;
        hold_seq_d   = hold_seq_q;
        hold_bmask_d = hold_bmask_q & ~clr;
        if (grant_en) begin
            state_d      = ST_FULL;
            hold_pkt_d   = req_pkt[win_idx];
            hold_seq_d   = req_seq[win_idx];
            hold_bmask_d = req_bmask[win_idx] & ~clr;
        end else if (free) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            hold_pkt_q   <= '0;
            hold_seq_q   <= '0;
            hold_bmask_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_pkt_q   <= hold_pkt_d;
            hold_seq_q   <= hold_seq_d;
            hold_bmask_q <= hold_bmask_d;
        end
    end

    assign issue_valid = hold_valid & ~hold_kill;
    assign issue_pkt   = hold_pkt_q;
    assign issue_seq   = hold_seq_q;
    assign issue_bmask = hold_bmask_q & ~clr;

endmodule

// File: tb/tb_branch_issue_sched.sv
// Directed testbench for branch_issue_sched: hand-computed expectations for
// arbitration, wrap-around age, stall, mispredict, correct resolve and reset.
module tb_branch_issue_sched;

    localparam int NUM_REQ = 4;
    localparam int SEQ_W   = 5;
    localparam int BM_W    = 4;
    localparam int PKT_W   = 128;

    logic                          clock;
    logic                          reset;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][SEQ_W-1:0] req_seq;
    logic [NUM_REQ-1:0][BM_W-1:0]  req_bmask;
    logic [NUM_REQ-1:0][PKT_W-1:0] req_pkt;
    logic [NUM_REQ-1:0]            req_grant;
    logic [SEQ_W-1:0]              head_seq;
    logic                          issue_valid;
    logic [PKT_W-1:0]              issue_pkt;
    logic [SEQ_W-1:0]              issue_seq;
    logic [BM_W-1:0]               issue_bmask;
    logic                          fu_ready;
    logic                          resolve_valid;
    logic                          resolve_mispred;
    logic [BM_W-1:0]               resolve_bm;

    int n_pass;
    int n_chk;

    branch_issue_sched #(
        .NUM_REQ(NUM_REQ), .SEQ_W(SEQ_W), .BM_W(BM_W), .PKT_W(PKT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_seq         (req_seq),
        .req_bmask       (req_bmask),
        .req_pkt         (req_pkt),
        .req_grant       (req_grant),
        .head_seq        (head_seq),
        .issue_valid     (issue_valid),
        .issue_pkt       (issue_pkt),
        .issue_seq       (issue_seq),
        .issue_bmask     (issue_bmask),
        .fu_ready        (fu_ready),
        .resolve_valid   (resolve_valid),
        .resolve_mispred (resolve_mispred),
        .resolve_bm      (resolve_bm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [PKT_W-1:0] pkt_of(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, ~w, w, 32'(i) * 32'h0101_0101};
    endfunction

    task automatic chk(input string tag, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Advance one clock; inputs are changed 1ns after the edge by the caller.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        reset = 1'b1;
        req_valid = '0;
        req_seq = '0;
        req_bmask = '0;
        for (int i = 0; i < NUM_REQ; i++) req_pkt[i] = pkt_of(i);
        head_seq = '0;
        fu_ready = 1'b0;
        resolve_valid = 1'b0;
        resolve_mispred = 1'b0;
        resolve_bm = '0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("rst_issue_valid", PKT_W'(issue_valid), 0);
        chk("rst_grant", PKT_W'(req_grant), 0);
        chk("rst_issue_seq", PKT_W'(issue_seq), 0);

        // Basic oldest-first: head=4, seq0=7 (age 3), seq2=5 (age 1)
        head_seq = 5'd4; fu_ready = 1'b1;
        req_valid = 4'b0101; req_seq[0] = 5'd7; req_seq[2] = 5'd5;
        settle();
        chk("basic_grant", PKT_W'(req_grant), PKT_W'(4'b0100));
        tick();
        req_valid = '0;
        settle();
        chk("basic_issue_valid", PKT_W'(issue_valid), 1);
        chk("basic_issue_seq", PKT_W'(issue_seq), 5);
        chk("basic_issue_pkt", issue_pkt, pkt_of(2));

        // Wrap: head=30, seq1=31 (age 1), seq3=2 (age 4); back-to-back with full hold
        head_seq = 5'd30; req_valid = 4'b1010; req_seq[1] = 5'd31; req_seq[3] = 5'd2;
        settle();
        chk("wrap1_grant", PKT_W'(req_grant), PKT_W'(4'b0010));
        tick();
        // head=1, seq3=2 (age 1), seq0=0 (age 31)
        head_seq = 5'd1; req_valid = 4'b1001; req_seq[0] = 5'd0;
        settle();
        chk("wrap1_issue_seq", PKT_W'(issue_seq), 31);
        chk("wrap2_grant", PKT_W'(req_grant), PKT_W'(4'b1000));
        tick();
        req_valid = 4'b0001; req_seq[0] = 5'd3; req_bmask[0] = 4'b0010; fu_ready = 1'b0;
        settle();
        chk("wrap2_issue_seq", PKT_W'(issue_seq), 2);

        // Stall 3 cycles with port 0 pending
        for (int c = 0; c < 3; c++) begin
            chk("stall_grant", PKT_W'(req_grant), 0);
            chk("stall_issue_valid", PKT_W'(issue_valid), 1);
            chk("stall_issue_seq", PKT_W'(issue_seq), 2);
            chk("stall_issue_pkt", issue_pkt, pkt_of(3));
            tick();
        end
        fu_ready = 1'b1;
        settle();
        chk("unstall_grant", PKT_W'(req_grant), PKT_W'(4'b0001));
        tick();
        req_valid = '0; fu_ready = 1'b0;
        settle();
        chk("unstall_issue_seq", PKT_W'(issue_seq), 3);
        chk("unstall_issue_bmask", PKT_W'(issue_bmask), PKT_W'(4'b0010));

        // Mispredict on bit 1: held entry and port 2 killed, port 0 survives
        req_valid = 4'b1111;
        req_seq[0] = 5'd2; req_seq[1] = 5'd10; req_seq[2] = 5'd3; req_seq[3] = 5'd12;
        req_bmask[0] = 4'b0001; req_bmask[1] = 4'b0000; req_bmask[2] = 4'b0010; req_bmask[3] = 4'b0000;
        resolve_valid = 1'b1; resolve_mispred = 1'b1; resolve_bm = 4'b0010;
        settle();
        chk("mis_issue_valid", PKT_W'(issue_valid), 0);
        chk("mis_grant", PKT_W'(req_grant), PKT_W'(4'b0001));
        tick();
        req_valid = '0; resolve_valid = 1'b0; resolve_mispred = 1'b0; resolve_bm = '0;
        settle();
        chk("mis_issue_valid_next", PKT_W'(issue_valid), 1);
        chk("mis_issue_bmask", PKT_W'(issue_bmask), PKT_W'(4'b0001));
        chk("mis_issue_seq", PKT_W'(issue_seq), 2);

        // Load a held entry with bmask 0110
        fu_ready = 1'b1; req_valid = 4'b0010; req_seq[1] = 5'd5; req_bmask[1] = 4'b0110;
        settle();
        chk("cr_load_grant", PKT_W'(req_grant), PKT_W'(4'b0010));
        tick();
        // Correct resolve of bit 2 while stalled
        fu_ready = 1'b0; req_valid = 4'b1000; req_seq[3] = 5'd4; req_bmask[3] = 4'b0101;
        resolve_valid = 1'b1; resolve_mispred = 1'b0; resolve_bm = 4'b0100;
        settle();
        chk("cr_bmask_now", PKT_W'(issue_bmask), PKT_W'(4'b0010));
        chk("cr_stall_grant", PKT_W'(req_grant), 0);
        chk("cr_issue_valid", PKT_W'(issue_valid), 1);
        tick();
        resolve_valid = 1'b0; resolve_bm = '0;
        settle();
        chk("cr_bmask_after", PKT_W'(issue_bmask), PKT_W'(4'b0010));
        // Grant concurrent with correct resolve: 0101 latches as 0001
        fu_ready = 1'b1; resolve_valid = 1'b1; resolve_bm = 4'b0100;
        settle();
        chk("cr_grant", PKT_W'(req_grant), PKT_W'(4'b1000));
        tick();
        req_valid = '0; resolve_valid = 1'b0; resolve_bm = '0; fu_ready = 1'b0;
        settle();
        chk("cr_latched_bmask", PKT_W'(issue_bmask), PKT_W'(4'b0001));
        chk("cr_latched_seq", PKT_W'(issue_seq), 4);

        // Kill the held entry with no requests: register empties
        resolve_valid = 1'b1; resolve_mispred = 1'b1; resolve_bm = 4'b0001;
        settle();
        chk("kill_issue_valid", PKT_W'(issue_valid), 0);
        tick();
        resolve_valid = 1'b0; resolve_mispred = 1'b0; resolve_bm = '0;
        settle();
        chk("kill_empty", PKT_W'(issue_valid), 0);

        // Tie on age: ports 1 and 3 equal tags, lowest index wins
        head_seq = 5'd1; req_valid = 4'b1010; req_seq[1] = 5'd6; req_seq[3] = 5'd6;
        req_bmask[1] = '0; req_bmask[3] = '0;
        settle();
        chk("tie_grant", PKT_W'(req_grant), PKT_W'(4'b0010));
        tick();
        req_valid = 4'b1111; fu_ready = 1'b0;
        settle();
        chk("tie_issue_pkt", issue_pkt, pkt_of(1));

        // Reset while full and stalled with all ports requesting
        reset = 1'b1;
        settle();
        chk("rst_mid_grant", PKT_W'(req_grant), 0);
        tick();
        reset = 1'b0; req_valid = '0;
        settle();
        chk("rst_mid_issue_valid", PKT_W'(issue_valid), 0);
        chk("rst_mid_issue_seq", PKT_W'(issue_seq), 0);
        req_valid = 4'b0100; req_seq[2] = 5'd9; req_bmask[2] = 4'b1000;
        settle();
        chk("post_rst_grant", PKT_W'(req_grant), PKT_W'(4'b0100));
        tick();
        req_valid = '0;
        settle();
        chk("post_rst_issue_seq", PKT_W'(issue_seq), 9);
        chk("post_rst_issue_bmask", PKT_W'(issue_bmask), PKT_W'(4'b1000));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
